// File: rtl/pes_pkg.sv
// Shared types and constants for the pes_add operand feeder.
// Slot k of an operand set is a(k/2) for even k and b(k/2) for odd k.
package pes_pkg;

  localparam int DATA_W = 8;
  localparam int SLOTS  = 8;
  localparam int SLOT_W = 3;

  typedef logic [DATA_W-1:0] operand_t;
  typedef operand_t [SLOTS-1:0] opset_t;

  localparam logic [SLOT_W-1:0] SLOT_A0 = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_B0 = 3'd1;
  localparam logic [SLOT_W-1:0] SLOT_A1 = 3'd2;
  localparam logic [SLOT_W-1:0] SLOT_B1 = 3'd3;
  localparam logic [SLOT_W-1:0] SLOT_A2 = 3'd4;
  localparam logic [SLOT_W-1:0] SLOT_B2 = 3'd5;
  localparam logic [SLOT_W-1:0] SLOT_A3 = 3'd6;
  localparam logic [SLOT_W-1:0] SLOT_B3 = 3'd7;

endpackage

// File: rtl/pes_operand_loader_if.sv
// Byte-in / operand-set-out bus of the operand loader.
// The master side feeds bytes and consumes sets; the slave side is the loader.
interface pes_operand_loader_if #(
  parameter int DROP_W = 8
);
  import pes_pkg::*;

  operand_t            in_data;
  logic                in_valid;
  logic                in_sof;
  logic                in_ready;
  operand_t            a0, a1, a2, a3;
  operand_t            b0, b1, b2, b3;
  logic                out_valid;
  logic                out_ready;
  logic [DROP_W-1:0]   drop_cnt;

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, a0, a1, a2, a3, b0, b1, b2, b3, out_valid, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, a0, a1, a2, a3, b0, b1, b2, b3, out_valid, drop_cnt
  );

endinterface

// File: rtl/pes_operand_bank.sv
// Eight-entry operand register file: one indexed write port, full parallel read-out.
module pes_operand_bank
  import pes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SLOT_W-1:0] widx,
  input  operand_t          wdata,
  output opset_t            rdata
);

  opset_t mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem;

endmodule

// File: rtl/pes_operand_loader.sv
// Collects a byte stream into ping-pong operand sets and presents one set at a time
// to the combinational adder tree with a valid/ready handshake.
module pes_operand_loader
  import pes_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pes_operand_loader_if.slave   bus
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [SLOT_W-1:0] slot;
  logic [DROP_W-1:0] drop_cnt_q;

  logic              accept;
  logic              complete;
  logic              rel_set;
  logic [SLOT_W-1:0] widx;
  logic [1:0]        set_m;
  logic [1:0]        clr_m;
  opset_t            rd0, rd1, cur;

  assign accept   = bus.in_valid && !full[wr_bank];
  // A start-of-frame byte always lands in slot 0, so it can never complete a set.
  assign widx     = bus.in_sof ? SLOT_A0 : slot;
  assign complete = accept && !bus.in_sof && (slot == SLOT_B3);
  assign rel_set  = full[rd_bank] && bus.out_ready;

  always_comb begin
    set_m = 2'b00;
    clr_m = 2'b00;
    if (complete) set_m[wr_bank] = 1'b1;
    if (rel_set)  clr_m[rd_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      slot       <= '0;
      drop_cnt_q <= '0;
    end else begin
      full <= (full & ~clr_m) | set_m;
      if (rel_set) rd_bank <= ~rd_bank;
      if (accept) begin
        if (bus.in_sof) begin
          slot <= SLOT_B0;
          if (slot != SLOT_A0) drop_cnt_q <= sat_inc(drop_cnt_q);
        end else if (complete) begin
          slot    <= SLOT_A0;
          wr_bank <= ~wr_bank;
        end else begin
          slot <= slot + 3'd1;
        end
      end
    end
  end

  pes_operand_bank u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !wr_bank),
    .widx  (widx),
    .wdata (bus.in_data),
    .rdata (rd0)
  );

  pes_operand_bank u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && wr_bank),
    .widx  (widx),
    .wdata (bus.in_data),
    .rdata (rd1)
  );

  assign cur = rd_bank ? rd1 : rd0;

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.a0        = cur[SLOT_A0];
  assign bus.b0        = cur[SLOT_B0];
  assign bus.a1        = cur[SLOT_A1];
  assign bus.b1        = cur[SLOT_B1];
  assign bus.a2        = cur[SLOT_A2];
  assign bus.b2        = cur[SLOT_B2];
  assign bus.a3        = cur[SLOT_A3];
  assign bus.b3        = cur[SLOT_B3];

endmodule

// File: tb/tb_pes_operand_loader.sv
// Bench for pes_operand_loader: directed scenarios plus a random phase, each cycle
// compared against a queue-based model of completed and partial operand sets.
module tb_pes_operand_loader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pes_operand_loader_if #(.DROP_W(8)) bus ();

  pes_operand_loader #(.DROP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_vld    = 0;
  int n_nordy  = 0;

  // Reference model: list of complete sets waiting for the consumer, plus the frame being built.
  logic [63:0] m_sets[$];
  logic [63:0] m_part;
  int          m_part_cnt;
  int          m_drop;
  bit          m_rst_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dut_set();
    return {bus.b3, bus.a3, bus.b2, bus.a2, bus.b1, bus.a1, bus.b0, bus.a0};
  endfunction

  task automatic model_reset();
    m_sets.delete();
    m_part     = '0;
    m_part_cnt = 0;
    m_drop     = 0;
    m_rst_seen = 1'b1;
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(bus.in_ready), 64'(m_sets.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(m_sets.size() > 0));
    chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
    if (m_sets.size() > 0) chk("opset", dut_set(), m_sets[0]);
    if (m_rst_seen) chk("rst_ops", dut_set(), 64'd0);
    if (bus.out_valid) n_vld++;
    if (!bus.in_ready) n_nordy++;
  endtask

  task automatic model_update(input logic r, input logic v, input logic s,
                              input logic [7:0] d, input logic o);
    bit acc, rel;
    if (r) begin
      model_reset();
      return;
    end
    m_rst_seen = 1'b0;
    acc = v && (m_sets.size() < 2);
    rel = (m_sets.size() > 0) && o;
    if (rel) void'(m_sets.pop_front());
    if (acc) begin
      if (s) begin
        if (m_part_cnt != 0 && m_drop < 255) m_drop++;
        m_part     = '0;
        m_part[7:0] = d;
        m_part_cnt = 1;
      end else begin
        m_part[8*m_part_cnt +: 8] = d;
        m_part_cnt++;
        if (m_part_cnt == 8) begin
          m_sets.push_back(m_part);
          m_part     = '0;
          m_part_cnt = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s,
                      input logic [7:0] d, input logic o);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_data   = d;
    bus.out_ready = o;
    check_outputs();
    model_update(r, v, s, d, o);
  endtask

  task automatic idle(input logic o);
    step(1'b0, 1'b0, 1'b0, 8'h00, o);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] rd;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // 1: one set, consumer idle
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
    idle(1'b0);
    chk("t1_a0", 64'(bus.a0), 64'h01);
    chk("t1_b0", 64'(bus.b0), 64'h02);
    chk("t1_a1", 64'(bus.a1), 64'h03);
    chk("t1_b3", 64'(bus.b3), 64'h08);
    chk("t1_in_ready", 64'(bus.in_ready), 64'd1);

    // 2: second set fills the other bank, then backpressure
    for (int i = 9; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
    idle(1'b0);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h11, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    chk("t2_a0", 64'(bus.a0), 64'h09);
    chk("t2_b3", 64'(bus.b3), 64'h10);
    chk("t2_in_ready_back", 64'(bus.in_ready), 64'd1);
    idle(1'b0);

    // 3: start-of-frame resync after a partial frame
    do_reset();
    step(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'hA2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'hA3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    idle(1'b0);
    chk("t3_drop", 64'(bus.drop_cnt), 64'd1);
    chk("t3_a0", 64'(bus.a0), 64'h10);
    chk("t3_b3", 64'(bus.b3), 64'h17);
    step(1'b0, 1'b1, 1'b1, 8'h30, 1'b0);
    idle(1'b0);
    chk("t3_drop_slot0", 64'(bus.drop_cnt), 64'd1);

    // 4: streaming with the consumer always ready
    do_reset();
    n_vld   = 0;
    n_nordy = 0;
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1, 1'b0, rd, 1'b1);
    end
    idle(1'b1);
    chk("t4_sets", 64'(n_vld), 64'd5);
    chk("t4_stalls", 64'(n_nordy), 64'd0);

    // 5: reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    idle(1'b0);
    chk("t5_a0", 64'(bus.a0), 64'h20);
    chk("t5_b3", 64'(bus.b3), 64'h27);
    chk("t5_drop", 64'(bus.drop_cnt), 64'd0);

    // 6: drop counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(i), 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'(i + 1), 1'b0);
    end
    idle(1'b0);
    chk("t6_drop_sat", 64'(bus.drop_cnt), 64'd255);

    // 7: random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rd = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), rd, $urandom_range(0, 1) == 1);
    end
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
